// File: rtl/decode_dispatch_buffer.sv
// In-order decode-to-dispatch FIFO with per-entry source-operand readiness,
// kept current by write-back wakeup broadcasts and bypassed to the outputs.
module decode_dispatch_buffer #(
  parameter int DEPTH     = 8,
  parameter int ENQ_WIDTH = 2,
  parameter int DEQ_WIDTH = 2,
  parameter int WB_PORTS  = 2,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ENQ_WIDTH-1:0]           in_valid,
  output logic                           in_ready,
  input  logic [ENQ_WIDTH-1:0]           in_uses_rs,
  input  logic [ENQ_WIDTH-1:0]           in_uses_rt,
  input  logic [ENQ_WIDTH*PREG_W-1:0]    in_phys_rs,
  input  logic [ENQ_WIDTH*PREG_W-1:0]    in_phys_rt,
  input  logic [ENQ_WIDTH-1:0]           in_rs_rdy,
  input  logic [ENQ_WIDTH-1:0]           in_rt_rdy,
  input  logic [ENQ_WIDTH*PAYLOAD_W-1:0] in_payload,
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]     wb_preg,
  output logic [DEQ_WIDTH-1:0]           out_valid,
  input  logic [DEQ_WIDTH-1:0]           out_accept,
  output logic [DEQ_WIDTH*PREG_W-1:0]    out_phys_rs,
  output logic [DEQ_WIDTH*PREG_W-1:0]    out_phys_rt,
  output logic [DEQ_WIDTH-1:0]           out_rs_rdy,
  output logic [DEQ_WIDTH-1:0]           out_rt_rdy,
  output logic [DEQ_WIDTH*PAYLOAD_W-1:0] out_payload,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d, n_enq, n_deq;
  logic [DEPTH-1:0]     valid_q, rs_rdy_q, rt_rdy_q;
  logic [PREG_W-1:0]    phys_rs_q [DEPTH];
  logic [PREG_W-1:0]    phys_rt_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic                 enq_fire;
  logic [ENQ_WIDTH-1:0] lane_rs_rdy, lane_rt_rdy;
  logic [PTR_W-1:0]     enq_idx [ENQ_WIDTH];
  logic [PTR_W-1:0]     deq_idx [DEQ_WIDTH];

  // Offsets never exceed DEPTH, so one conditional subtract wraps any DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] off);
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(p) + (CNT_W+1)'(off);
    if (s >= (CNT_W+1)'(DEPTH)) s = s - (CNT_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  function automatic logic wb_hit(input logic [PREG_W-1:0] preg,
                                  input logic [WB_PORTS-1:0] v,
                                  input logic [WB_PORTS*PREG_W-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++)
      if (v[k] && (p[k*PREG_W +: PREG_W] == preg)) hit = 1'b1;
    return hit;
  endfunction

  assign in_ready = (count_q <= CNT_W'(DEPTH - ENQ_WIDTH));
  assign count    = count_q;
  assign enq_fire = in_valid[0] & in_ready;

  always_comb begin
    n_enq = '0;
    n_deq = '0;
    if (enq_fire)
      for (int l = 0; l < ENQ_WIDTH; l++) n_enq = n_enq + CNT_W'(in_valid[l]);
    for (int j = 0; j < DEQ_WIDTH; j++) n_deq = n_deq + CNT_W'(out_accept[j]);
    head_d  = ptr_add(head_q, n_deq);
    tail_d  = ptr_add(tail_q, n_enq);
    count_d = count_q + n_enq - n_deq;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq
      assign enq_idx[gi]     = ptr_add(tail_q, CNT_W'(gi));
      assign lane_rs_rdy[gi] = ~in_uses_rs[gi] | in_rs_rdy[gi]
                             | (in_phys_rs[gi*PREG_W +: PREG_W] == '0)
                             | wb_hit(in_phys_rs[gi*PREG_W +: PREG_W], wb_valid, wb_preg);
      assign lane_rt_rdy[gi] = ~in_uses_rt[gi] | in_rt_rdy[gi]
                             | (in_phys_rt[gi*PREG_W +: PREG_W] == '0)
                             | wb_hit(in_phys_rt[gi*PREG_W +: PREG_W], wb_valid, wb_preg);
    end

    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
      assign deq_idx[gi]                          = ptr_add(head_q, CNT_W'(gi));
      assign out_valid[gi]                        = CNT_W'(gi) < count_q;
      assign out_phys_rs[gi*PREG_W +: PREG_W]     = phys_rs_q[deq_idx[gi]];
      assign out_phys_rt[gi*PREG_W +: PREG_W]     = phys_rt_q[deq_idx[gi]];
      assign out_payload[gi*PAYLOAD_W +: PAYLOAD_W] = payload_q[deq_idx[gi]];
      // Same-cycle bypass makes a wakeup visible to dispatch without waiting a cycle.
      assign out_rs_rdy[gi] = rs_rdy_q[deq_idx[gi]]
                            | wb_hit(phys_rs_q[deq_idx[gi]], wb_valid, wb_preg);
      assign out_rt_rdy[gi] = rt_rdy_q[deq_idx[gi]]
                            | wb_hit(phys_rt_q[deq_idx[gi]], wb_valid, wb_preg);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && wb_hit(phys_rs_q[i], wb_valid, wb_preg)) rs_rdy_q[i] <= 1'b1;
        if (valid_q[i] && wb_hit(phys_rt_q[i], wb_valid, wb_preg)) rt_rdy_q[i] <= 1'b1;
      end
      for (int j = 0; j < DEQ_WIDTH; j++)
        if (out_accept[j]) valid_q[deq_idx[j]] <= 1'b0;
      // Enqueue slots are always free, so they never collide with dequeued ones.
      for (int l = 0; l < ENQ_WIDTH; l++) begin
        if (enq_fire && in_valid[l]) begin
          valid_q[enq_idx[l]]  <= 1'b1;
          rs_rdy_q[enq_idx[l]] <= lane_rs_rdy[l];
          rt_rdy_q[enq_idx[l]] <= lane_rt_rdy[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      if (enq_fire && in_valid[l]) begin
        phys_rs_q[enq_idx[l]] <= in_phys_rs[l*PREG_W +: PREG_W];
        phys_rt_q[enq_idx[l]] <= in_phys_rt[l*PREG_W +: PREG_W];
        payload_q[enq_idx[l]] <= in_payload[l*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

endmodule

// File: doc/decode_dispatch_buffer.md
Name: decode_dispatch_buffer

Overview:
- Parametrised in-order FIFO between rename/decode and the issue queues.
- Replaces the fixed two-slot decode pass-through, which has no storage of its own and only a hazard-driven slot 1.
- Accepts up to ENQ_WIDTH renamed instructions per cycle and presents the oldest DEQ_WIDTH to dispatch.
- Tracks per-entry source-operand readiness, updated by write-back wakeup broadcasts, so dispatch never sees a stale valid bit.

Parameters:
- DEPTH, 8: entries; any value >= max(ENQ_WIDTH, DEQ_WIDTH).
- ENQ_WIDTH, 2: enqueue lanes.
- DEQ_WIDTH, 2: dequeue lanes.
- WB_PORTS, 2: wakeup broadcast ports (load write-back plus ALU write-back).
- PREG_W, 6: physical register index width.
- PAYLOAD_W, 128: opaque payload width. Carries immediate, uses_immediate, is_branch, prediction, recovery_target, is_mem_access, mem_action and active_list_id.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict/recovery flush; empties the buffer
- in_valid  in  ENQ_WIDTH  per-lane enqueue valid; must be a contiguous prefix (lane i valid implies lanes below i valid)
- in_ready  out  1  all-or-nothing: free slots >= ENQ_WIDTH
- in_uses_rs  in  ENQ_WIDTH  per-lane uses_rs
- in_uses_rt  in  ENQ_WIDTH  per-lane uses_rt
- in_phys_rs  in  ENQ_WIDTH*PREG_W  per-lane phys_rs
- in_phys_rt  in  ENQ_WIDTH*PREG_W  per-lane phys_rt
- in_rs_rdy  in  ENQ_WIDTH  register-file valid bit for phys_rs at rename
- in_rt_rdy  in  ENQ_WIDTH  register-file valid bit for phys_rt at rename
- in_payload  in  ENQ_WIDTH*PAYLOAD_W  per-lane payload
- wb_valid  in  WB_PORTS  wakeup valid
- wb_preg  in  WB_PORTS*PREG_W  woken physical register
- out_valid  out  DEQ_WIDTH  lane j holds the j-th oldest entry
- out_accept  in  DEQ_WIDTH  consumer takes lane j; contiguous prefix, and a subset of out_valid
- out_phys_rs  out  DEQ_WIDTH*PREG_W  per-lane phys_rs
- out_phys_rt  out  DEQ_WIDTH*PREG_W  per-lane phys_rt
- out_rs_rdy  out  DEQ_WIDTH  per-lane effective rs ready
- out_rt_rdy  out  DEQ_WIDTH  per-lane effective rt ready
- out_payload  out  DEQ_WIDTH*PAYLOAD_W  per-lane payload, unmodified
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Storage: circular array with head and tail pointers. Pointers wrap modulo DEPTH and are explicit for non-power-of-2 DEPTH.
- Reset (rst=1 at a clk edge): head=tail=0, count=0, all entry valids cleared. In the cycle after, out_valid=0 and in_ready=1. Reset overrides flush, enqueue and dequeue.
- Flush: head=tail=0, count=0 at the next edge; same-cycle enqueue and dequeue are discarded. Priority order: rst > flush > deq/enq.
- Enqueue: takes effect when in_valid[0] & in_ready. Lanes 0..n-1 are written at tail..tail+n-1 and tail advances by n. A non-prefix in_valid is a protocol error and need not be handled.
- in_ready depends only on registered count (DEPTH-count >= ENQ_WIDTH). It does not consider same-cycle dequeue; no combinational path from out_accept.
- Dequeue: k = popcount(out_accept). head advances by k; count_next = count + n - k. Enqueue and dequeue in the same cycle are both honoured.
- Output lane j is driven combinationally from entry (head+j) mod DEPTH; out_valid[j] = (j < count).
- Operand ready rules:
  - Stored bit is set when uses_rs=0, when phys_rs==0, or when in_rs_rdy=1 at enqueue. Same rules apply to rt.
  - Wakeup: any wb_valid[k] whose wb_preg matches a valid entry's phys_rs/rt sets that stored bit at the edge.
  - Wakeup also applies to lanes enqueuing in the same cycle, so they are not lost.
  - Outputs: out_rs_rdy = stored bit OR same-cycle wb match. This bypass gives zero-cycle wakeup visibility. Same for rt.
  - Ready bits never clear except via entry invalidation.
- Full: in_ready=0 whenever count > DEPTH-ENQ_WIDTH; in_valid is ignored while in_ready=0.
- Empty: out_valid=0; out_accept must be 0.
- Duplicate wakeups, or a wakeup for a non-present register, are harmless.
- Latency: 1 cycle from enqueue to out_valid.

Test Plan:
- DEPTH=8 after reset: enqueue 2/cycle for 4 cycles with no accept -> count 2,4,6,8; in_ready drops to 0 when count=8 (actually at count=7+ i.e. >6); 5th enqueue ignored.
- Fill 5 entries, accept 2/cycle while enqueuing 2/cycle -> count stays 5, FIFO order preserved across pointer wrap (head 6->0).
- Entry with phys_rs=12, in_rs_rdy=0 at head: out_rs_rdy=0. Drive wb_preg=12 -> out_rs_rdy=1 the same cycle and stays 1 after the edge.
- Enqueue lane 1 with phys_rt=9, rt not ready, while wb_preg[1]=9 in the same cycle -> stored rt_rdy=1 next cycle.
- Buffer holds 6 entries; assert flush together with in_valid=2'b11 and out_accept=2'b01 -> next cycle count=0, out_valid=0, in_ready=1.
- rst asserted mid-stream with count=5 -> next cycle count=0; out_payload don't-care while out_valid=0.
